// File: rtl/pkg_parameters.sv
// Shared instruction-memory parameters and the imem_arb state type.
package pkg_parameters;
   localparam int IMEM_DEPTH      = 256;
   localparam int IMEM_ADDR_WIDTH = 12;
   localparam int IMEM_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2,
      FLUSH = 2'd3
   } imem_arb_state_t;
endpackage

// File: rtl/imem_arb.sv
// Arbitrates the instruction memory between core fetches and a byte loader.
// Optional load checksum output enabled by macro IMEM_ARB_LOAD_CHECKSUM_EN.
module imem_arb
   import pkg_parameters::*;
#(
   parameter int ADDR_W = IMEM_ADDR_WIDTH,
   parameter int DATA_W = IMEM_DATA_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_mode,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_rvalid,
   output logic [DATA_W-1:0] fetch_rdata,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data,
   output logic              ld_ready,
   output logic              ld_err,
`ifdef IMEM_ARB_LOAD_CHECKSUM_EN
   output logic [31:0]       ld_csum,
`endif
   output logic              core_flush,
   output logic              busy_load,
   output logic              mem_ena,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(IMEM_DEPTH);

   imem_arb_state_t r_state;
   logic            r_rvalid;
   logic            r_ld_err;
   logic            r_load_mode_d;

   logic w_lm_rise;
   logic w_fetch_issue;
   logic w_in_range;
   logic w_ld_accept;
   logic w_ld_write;

   assign w_lm_rise     = load_mode & ~r_load_mode_d;
   // A raised load_mode blocks new grants so only the in-flight read completes.
   assign w_fetch_issue = (r_state == FETCH) & fetch_req & ~load_mode;
   assign w_in_range    = ({1'b0, ld_addr} < LP_DEPTH);
   assign w_ld_accept   = (r_state == LOAD) & ld_valid;
   assign w_ld_write    = w_ld_accept & w_in_range;

   assign fetch_gnt    = w_fetch_issue;
   assign fetch_rvalid = r_rvalid;
   assign fetch_rdata  = r_rvalid ? mem_rdata : '0;
   assign ld_ready     = (r_state == LOAD);
   assign busy_load    = (r_state == LOAD);
   assign core_flush   = (r_state == FLUSH);
   assign ld_err       = r_ld_err;
   assign mem_ena      = w_fetch_issue | w_ld_write;
   assign mem_we       = w_ld_write;
   assign mem_addr     = w_ld_write ? ld_addr : (w_fetch_issue ? fetch_addr : '0);
   assign mem_wdata    = w_ld_write ? ld_data : '0;

`ifdef IMEM_ARB_LOAD_CHECKSUM_EN
   logic [31:0] r_csum;
   assign ld_csum = r_csum;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_rvalid      <= 1'b0;
         r_ld_err      <= 1'b0;
         r_load_mode_d <= 1'b0;
`ifdef IMEM_ARB_LOAD_CHECKSUM_EN
         r_csum        <= '0;
`endif
      end else begin
         r_load_mode_d <= load_mode;
         r_rvalid      <= w_fetch_issue;
         if (w_ld_accept && !w_in_range) begin
            r_ld_err <= 1'b1;
         end else if (w_lm_rise) begin
            r_ld_err <= 1'b0;
         end
`ifdef IMEM_ARB_LOAD_CHECKSUM_EN
         if (w_lm_rise) begin
            r_csum <= '0;
         end else if (w_ld_write) begin
            r_csum <= r_csum + 32'(ld_data);
         end
`endif
         case (r_state)
            IDLE: begin
               if (load_mode)      r_state <= LOAD;
               else if (fetch_req) r_state <= FETCH;
            end
            FETCH: begin
               if (load_mode)       r_state <= LOAD;
               else if (!fetch_req) r_state <= IDLE;
            end
            LOAD: begin
               if (!load_mode) r_state <= FLUSH;
            end
            FLUSH:   r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_arb.sv
// Scoreboard bench for imem_arb: directed fetch/load/error/reset sequences.
module tb_imem_arb;
   import pkg_parameters::*;
   localparam int AW = IMEM_ADDR_WIDTH;
   localparam int DW = IMEM_DATA_WIDTH;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_mode, fetch_req, ld_valid;
   logic [AW-1:0] fetch_addr, ld_addr;
   logic [7:0]    ld_data;
   logic          fetch_gnt, fetch_rvalid, ld_ready, ld_err, core_flush, busy_load;
   logic [DW-1:0] fetch_rdata, mem_rdata;
   logic          mem_ena, mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
`ifdef IMEM_ARB_LOAD_CHECKSUM_EN
   logic [31:0]   ld_csum;
`endif

   int checks = 0;
   int errors = 0;
   int flush_cnt = 0;
   logic [31:0] rd_q[$];
   logic [19:0] wr_q[$];
   logic [7:0]  mem_bytes [0:IMEM_DEPTH-1];

   always #5 clk = ~clk;

   imem_arb dut (
      .clk(clk), .rst_n(rst_n), .load_mode(load_mode),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
      .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_ready(ld_ready), .ld_err(ld_err),
`ifdef IMEM_ARB_LOAD_CHECKSUM_EN
      .ld_csum(ld_csum),
`endif
      .core_flush(core_flush), .busy_load(busy_load),
      .mem_ena(mem_ena), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Byte-wide memory with one-cycle registered word read (little endian).
   always @(posedge clk) begin
      if (mem_ena && mem_we && int'(mem_addr) < IMEM_DEPTH)
         mem_bytes[mem_addr] <= mem_wdata;
      if (mem_ena && !mem_we && int'(mem_addr) + 3 < IMEM_DEPTH)
         mem_rdata <= {mem_bytes[mem_addr+3], mem_bytes[mem_addr+2],
                       mem_bytes[mem_addr+1], mem_bytes[mem_addr]};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents read data or a write.
   always @(negedge clk) begin
      if (core_flush) flush_cnt++;
      if (fetch_rvalid) begin
         if (rd_q.size() == 0) chk("unexpected_rvalid", fetch_rdata, 32'hxxxx_xxxx);
         else chk("fetch_rdata", fetch_rdata, rd_q.pop_front());
      end
      if (mem_ena && mem_we) begin
         if (wr_q.size() == 0) chk("unexpected_write", {12'h0, mem_addr, mem_wdata}, 32'hxxxx_xxxx);
         else chk("mem_write_addr_data", {12'h0, mem_addr, mem_wdata}, {12'h0, wr_q.pop_front()});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic ld_byte(input logic [AW-1:0] a, input logic [7:0] d, input bit expect_wr);
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_data  = d;
      if (expect_wr) wr_q.push_back({a, d});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_outs"}, {22'h0, fetch_gnt, fetch_rvalid, ld_ready, ld_err, core_flush,
                          busy_load, mem_ena, mem_we, (|mem_addr), (|mem_wdata)}, 32'h0);
      chk({tag, "_rdata"}, fetch_rdata, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < IMEM_DEPTH; i++) mem_bytes[i] = 8'h00;
      {mem_bytes[3], mem_bytes[2], mem_bytes[1], mem_bytes[0]}   = 32'h00500093;
      {mem_bytes[7], mem_bytes[6], mem_bytes[5], mem_bytes[4]}   = 32'h00100113;
      {mem_bytes[11], mem_bytes[10], mem_bytes[9], mem_bytes[8]} = 32'hDEADBEEF;
      mem_rdata = '0;
      rst_n = 1'b0; load_mode = 1'b0; fetch_req = 1'b0; ld_valid = 1'b0;
      fetch_addr = '0; ld_addr = '0; ld_data = '0;
      step(); step(); smp();
      chk_all_zero("reset");
      step(); rst_n = 1'b1;

      // Fetch 0x00, 0x04, 0x08; load_mode rises with 0x08 in flight.
      fetch_req = 1'b1; fetch_addr = 12'h000;
      smp(); chk("c0_gnt", {31'h0, fetch_gnt}, 32'h0);
      step(); rd_q.push_back(32'h00500093);
      smp(); chk("c1_gnt", {31'h0, fetch_gnt}, 32'h1); chk("c1_addr", {20'h0, mem_addr}, 32'h0);
      step(); fetch_addr = 12'h004; rd_q.push_back(32'h00100113);
      smp(); chk("c2_gnt", {31'h0, fetch_gnt}, 32'h1); chk("c2_addr", {20'h0, mem_addr}, 32'h4);
      step(); fetch_addr = 12'h008; rd_q.push_back(32'hDEADBEEF);
      smp(); chk("c3_gnt", {31'h0, fetch_gnt}, 32'h1);
      step(); load_mode = 1'b1;
      smp(); chk("c4_gnt_rv", {30'h0, fetch_gnt, fetch_rvalid}, 32'h1);

      // Load 4 bytes; load_mode drops together with the last byte.
      step(); fetch_req = 1'b0; ld_byte(12'h000, 8'h13, 1'b1);
      smp(); chk("load_state", {28'h0, busy_load, ld_ready, fetch_gnt, mem_we}, 32'hD);
      step(); ld_byte(12'h001, 8'h05, 1'b1);
      step(); ld_byte(12'h002, 8'h10, 1'b1);
      step(); ld_byte(12'h003, 8'h00, 1'b1); load_mode = 1'b0;
      smp(); chk("last_byte_we", {31'h0, mem_we}, 32'h1);
      step(); ld_valid = 1'b0;
      smp(); chk("flush", {29'h0, core_flush, mem_ena, ld_ready}, 32'h4);
      step(); fetch_req = 1'b1; fetch_addr = 12'h000;
      smp(); chk("flush_once", flush_cnt, 32'd1); chk("flush_gone", {31'h0, core_flush}, 32'h0);
      step(); rd_q.push_back(32'h00100513);
      smp(); chk("refetch_gnt", {31'h0, fetch_gnt}, 32'h1);
      step(); fetch_req = 1'b0;
      step();

      // Out-of-range byte sets sticky ld_err; checksum over written bytes.
      load_mode = 1'b1;
      step(); ld_byte(12'h100, 8'hAA, 1'b0);
      smp(); chk("oor_no_write", {30'h0, mem_ena, mem_we}, 32'h0); chk("oor_ready", {31'h0, ld_ready}, 32'h1);
      step(); ld_byte(12'h010, 8'hFF, 1'b1);
      smp(); chk("ld_err_set", {31'h0, ld_err}, 32'h1);
      step(); ld_byte(12'h011, 8'h02, 1'b1);
      step(); ld_valid = 1'b0;
`ifdef IMEM_ARB_LOAD_CHECKSUM_EN
      smp(); chk("ld_csum", ld_csum, 32'h00000101);
`endif
      load_mode = 1'b0;
      step(); step(); step();
      smp(); chk("ld_err_sticky", {31'h0, ld_err}, 32'h1);
      load_mode = 1'b1;
      step();
      smp(); chk("ld_err_cleared", {31'h0, ld_err}, 32'h0);
`ifdef IMEM_ARB_LOAD_CHECKSUM_EN
      chk("ld_csum_cleared", ld_csum, 32'h0);
`endif

      // Reset during LOAD after 2 bytes.
      ld_byte(12'h020, 8'h11, 1'b1);
      step(); ld_byte(12'h021, 8'h22, 1'b1);
      step(); ld_valid = 1'b0; rst_n = 1'b0; load_mode = 1'b0; fetch_req = 1'b1;
      smp(); chk_all_zero("midload_reset");
      step(); rst_n = 1'b1; fetch_req = 1'b0;
      smp(); chk("post_reset_idle", {30'h0, busy_load, core_flush}, 32'h0);
      step();
      smp(); chk("no_flush_after_reset", flush_cnt, 32'd2);
      chk("rd_q_empty", rd_q.size(), 32'd0);
      chk("wr_q_empty", wr_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end
endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default pkg_parameters::IMEM_ADDR_WIDTH, meaning the byte-address width.
REQ-002 SHALL have parameter DATA_W, default pkg_parameters::IMEM_DATA_WIDTH (32), meaning the fetch word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port load_mode, input, 1, level; high requests exclusive loader ownership of the instruction memory.
REQ-006 SHALL have ports fetch_req (in, 1), fetch_addr (in, ADDR_W), fetch_gnt (out, 1), fetch_rvalid (out, 1) and fetch_rdata (out, DATA_W).
REQ-007 SHALL have ports ld_valid (in, 1), ld_addr (in, ADDR_W), ld_data (in, 8), ld_ready (out, 1) and ld_err (out, 1, sticky).
REQ-008 SHALL have ports core_flush (out, 1, pulse) and busy_load (out, 1).
REQ-009 SHALL have memory-side ports mem_ena, mem_we (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, 8) and mem_rdata (in, DATA_W); mem_rdata is valid 1 cycle after a read.

Function
REQ-010 SHALL implement the states IDLE, FETCH, LOAD and FLUSH.
REQ-011 IDLE SHALL go to LOAD when load_mode=1, else to FETCH when fetch_req=1; load_mode wins when both are set.
REQ-012 A fetch issue SHALL be combinational with the accepting cycle: fetch_gnt=1, mem_ena=1, mem_we=0, mem_addr=fetch_addr.
REQ-013 fetch_rvalid SHALL be 1 exactly one cycle after each fetch_gnt, with fetch_rdata=mem_rdata; total latency 1 cycle.
REQ-014 FETCH SHALL sustain one grant per cycle while fetch_req=1 and load_mode=0, and SHALL return to IDLE when fetch_req=0.
REQ-015 When load_mode rises in FETCH, the block SHALL issue no new grant, SHALL deliver the in-flight read's rvalid, and SHALL then enter LOAD.
REQ-016 In LOAD: ld_ready=1, busy_load=1 and fetch_gnt=0.
REQ-017 In LOAD, each ld_valid&ld_ready with ld_addr < IMEM_DEPTH SHALL cause mem_ena=1, mem_we=1, mem_addr=ld_addr and mem_wdata=ld_data in the same cycle.
REQ-018 A load byte with ld_addr >= IMEM_DEPTH SHALL be accepted, SHALL NOT be written, and SHALL set ld_err=1.
REQ-019 ld_err SHALL clear only on reset or on a load_mode rising edge.
REQ-020 When load_mode falls in LOAD, the block SHALL go to FLUSH; a byte presented in that same cycle SHALL still be written.
REQ-021 FLUSH SHALL last exactly 1 cycle, assert core_flush=1 with no memory access, and then go to IDLE.
REQ-022 Outside LOAD: ld_ready=0; outside FLUSH: core_flush=0.
REQ-023 Addresses SHALL be passed through unmodified; no wrap-around SHALL be applied to fetch addresses.

Reset
REQ-024 While rst_n=0, state SHALL be IDLE and fetch_gnt, fetch_rvalid, fetch_rdata, ld_ready, ld_err, core_flush, busy_load, mem_ena, mem_we, mem_addr and mem_wdata SHALL all be 0.
REQ-025 Reset asserted mid-LOAD SHALL abort the load; the next cycle after release SHALL be IDLE with no flush pulse.

Configuration
REQ-026 Macro IMEM_ARB_LOAD_CHECKSUM_EN SHALL control the load checksum feature.
REQ-027 With IMEM_ARB_LOAD_CHECKSUM_EN defined: output ld_csum (32) SHALL accumulate the modulo-2^32 sum of written ld_data bytes, clear on a load_mode rising edge and reset to 0.
REQ-028 Without IMEM_ARB_LOAD_CHECKSUM_EN: no ld_csum port and no accumulator logic.

Structure
REQ-029 State typedef imem_arb_state_t SHALL reside in pkg_parameters, alongside the existing IMEM_DEPTH, IMEM_ADDR_WIDTH and IMEM_DATA_WIDTH.
REQ-030 The block SHALL be single-module with no sub-module.
REQ-031 The memory-side ports SHALL be bundled by the instantiating top into imem_if.

Verification
REQ-032 Fetch at 0x00 then 0x04, with mem holding 0x00500093 and 0x00100113 -> gnt in cycles 1 and 2, rvalid in cycles 2 and 3 with that data.
REQ-033 load_mode rises while the fetch of 0x08 is in flight -> its rvalid is still delivered; the next cycle is LOAD with fetch_gnt=0.
REQ-034 Load 4 bytes 0x13,0x05,0x10,0x00 to 0x00..0x03, then drop load_mode -> 4 writes, one core_flush pulse, and a refetch of 0x00 returns 0x00100513.
REQ-035 Load byte to IMEM_DEPTH -> no mem_we, ld_err=1; ld_err stays 1 until the next load_mode rise.
REQ-036 rst_n low during LOAD after 2 bytes -> all outputs are 0, state is IDLE, and no core_flush occurs.
REQ-037 With IMEM_ARB_LOAD_CHECKSUM_EN, bytes 0xFF,0x02 -> ld_csum=0x00000101.
